// File: rtl/product_bcd_conv.sv
// product_bcd_conv: sequential 8-bit binary to 3-digit packed BCD converter.
// It runs an 8-iteration double-dabble, one iteration per clock, and reports
// the number of significant digits so the display stage can blank leading zeros.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a product; mp_ready high
// CONV  | one double-dabble iteration per edge, 8 edges in total
// DONE  | result presented with bcd_valid; waiting for bcd_ready
module product_bcd_conv (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [7:0]  mp_in,
   input  logic        mp_valid,
   output logic        mp_ready,
   output logic [11:0] bcd_out,
   output logic [1:0]  digit_cnt,
   output logic        bcd_valid,
   input  logic        bcd_ready,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [19:0] shift_q;
   logic [19:0] shift_adj;
   logic [19:0] shift_nxt;
   logic [3:0]  iter_q;
   logic        last_iter;
   logic [1:0]  cnt_nxt;

   // Add 3 to a BCD nibble that would overflow past 9 after the next shift.
   function automatic logic [3:0] dabble(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // One double-dabble iteration and the digit count of its result.
   always_comb begin
      shift_adj = {dabble(shift_q[19:16]), dabble(shift_q[15:12]),
                   dabble(shift_q[11:8]), shift_q[7:0]};
      shift_nxt = {shift_adj[18:0], 1'b0};
      last_iter = (iter_q == 4'd7);
      if (shift_nxt[19:16] != 4'd0)
         cnt_nxt = 2'd3;
      else if (shift_nxt[15:12] != 4'd0)
         cnt_nxt = 2'd2;
      else
         cnt_nxt = 2'd1;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mp_valid)  state_nxt = CONV;
         CONV:    if (last_iter) state_nxt = DONE;
         DONE:    if (bcd_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Shift register, iteration counter and held result.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         shift_q   <= 20'h0;
         iter_q    <= 4'd0;
         bcd_out   <= 12'h000;
         digit_cnt <= 2'd1;
      end else begin
         case (state)
            IDLE: begin
               if (mp_valid) begin
                  shift_q <= {12'h000, mp_in};
                  iter_q  <= 4'd0;
               end
            end
            CONV: begin
               shift_q <= shift_nxt;
               iter_q  <= iter_q + 4'd1;
               if (last_iter) begin
                  bcd_out   <= shift_nxt[19:8];
                  digit_cnt <= cnt_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs are decoded from state; reset only masks mp_ready so
   // upstream never sees a handshake while the block is being reset.
   assign mp_ready  = (state == IDLE) && !sys_rst;
   assign bcd_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for product_bcd_conv with a result scoreboard.
module tb_product_bcd_conv;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic [7:0]  mp_in;
   logic        mp_valid;
   logic        mp_ready;
   logic [11:0] bcd_out;
   logic [1:0]  digit_cnt;
   logic        bcd_valid;
   logic        bcd_ready;
   logic        busy;

   typedef struct {
      logic [11:0] bcd;
      logic [1:0]  cnt;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;
   bit   seen   = 0;

   product_bcd_conv dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .mp_in     (mp_in),
      .mp_valid  (mp_valid),
      .mp_ready  (mp_ready),
      .bcd_out   (bcd_out),
      .digit_cnt (digit_cnt),
      .bcd_valid (bcd_valid),
      .bcd_ready (bcd_ready),
      .busy      (busy)
   );

   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] v, input int acc);
      exp_t e;
      int   n;
      n     = int'(v);
      e.bcd = {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
      e.cnt = (n >= 100) ? 2'd3 : (n >= 10) ? 2'd2 : 2'd1;
      e.acc = acc;
      return e;
   endfunction

   // Scoreboard: compare each fresh result against the oldest expectation.
   always @(negedge sys_clk) begin
      exp_t e;
      if (bcd_valid && !seen) begin
         seen = 1;
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL phantom_result got bcd=%h expected no result", bcd_out);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
            chk("digit_cnt", 32'(digit_cnt), 32'(e.cnt));
            chk("latency", 32'(cyc - e.acc), 32'd8);
         end
      end else if (!bcd_valid) begin
         seen = 0;
      end
   end

   task automatic send(input logic [7:0] v, output int acc);
      int g;
      g = 0;
      @(negedge sys_clk);
      while (!mp_ready && g < 100) begin
         @(negedge sys_clk);
         g++;
      end
      chk("send_timeout", 32'(g < 100), 32'd1);
      mp_in    = v;
      mp_valid = 1'b1;
      @(posedge sys_clk);
      #1;
      acc = cyc;
      sb.push_back(model(v, acc));
      mp_valid = 1'b0;
      mp_in    = ~v;
   endtask

   task automatic wait_valid();
      int g;
      g = 0;
      while (!bcd_valid && g < 40) begin
         @(negedge sys_clk);
         g++;
      end
      chk("valid_timeout", 32'(g < 40), 32'd1);
   endtask

   initial begin
      int a, b, prev;
      exp_t dropped;
      sys_rst   = 1'b1;
      mp_valid  = 1'b0;
      mp_in     = 8'h00;
      bcd_ready = 1'b1;
      repeat (3) @(negedge sys_clk);
      chk("rst_mp_ready", 32'(mp_ready), 32'd0);
      chk("rst_bcd_valid", 32'(bcd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_bcd_out", 32'(bcd_out), 32'h000);
      chk("rst_digit_cnt", 32'(digit_cnt), 32'd1);
      sys_rst = 1'b0;
      #1;
      chk("post_rst_mp_ready", 32'(mp_ready), 32'd1);

      // Zero, extremes and the largest real product.
      send(8'd0, a);
      wait_valid();
      send(8'd255, a);
      wait_valid();
      send(8'd225, a);

      // Back-to-back with bcd_ready tied high.
      send(8'd99, a);
      send(8'd7, b);
      chk("b2b_spacing", 32'(b - a), 32'd10);
      wait_valid();

      // Stall in DONE; a mp_valid pulse during the stall must be ignored.
      @(negedge sys_clk);
      bcd_ready = 1'b0;
      send(8'd123, a);
      wait_valid();
      for (int i = 0; i < 20; i++) begin
         @(negedge sys_clk);
         if (i == 5) begin
            mp_in    = 8'd42;
            mp_valid = 1'b1;
         end else begin
            mp_valid = 1'b0;
         end
         chk("stall_valid", 32'(bcd_valid), 32'd1);
         chk("stall_bcd", 32'(bcd_out), 32'h123);
         chk("stall_mp_ready", 32'(mp_ready), 32'd0);
      end
      mp_valid  = 1'b0;
      bcd_ready = 1'b1;
      @(negedge sys_clk);
      chk("release_valid", 32'(bcd_valid), 32'd0);
      chk("release_mp_ready", 32'(mp_ready), 32'd1);
      for (int i = 0; i < 12; i++) begin
         @(negedge sys_clk);
         chk("no_phantom_busy", 32'(busy), 32'd0);
         chk("hold_bcd", 32'(bcd_out), 32'h123);
      end

      // Reset on the 4th CONV edge aborts the conversion.
      send(8'd200, a);
      dropped = sb.pop_back();
      for (int g = 0; g < 20 && cyc < a + 3; g++) @(negedge sys_clk);
      chk("abort_align", 32'(cyc), 32'(a + 3));
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(bcd_valid), 32'd0);
      chk("abort_bcd", 32'(bcd_out), 32'h000);
      chk("abort_cnt", 32'(digit_cnt), 32'd1);
      chk("abort_mp_ready", 32'(mp_ready), 32'd1);
      chk("abort_dropped_bcd", 32'(dropped.bcd), 32'h200);
      send(8'd200, a);
      wait_valid();

      // Exhaustive sweep at full throughput.
      prev = 0;
      for (int v = 0; v < 256; v++) begin
         send(8'(v), a);
         if (v > 0) chk("sweep_spacing", 32'(a - prev), 32'd10);
         prev = a;
      end
      repeat (12) @(negedge sys_clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
